pipe_stage_reg: RTL

Generic parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It replaces the hand-written per-stage registers: a stage's control and data fields are packed into one payload vector. Unlike a plain clear-only stage, it supports back-pressure (stall) without dropping data. With SKID=1 it breaks the combinational ready path between stages.

---
 rtl/pipe_stage_reg.sv | 118 +++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with a valid/ready handshake and synchronous flush.
// SKID=1 adds a second entry so that in_ready is registered and does not depend on out_ready.

module pipe_stage_reg #(
    parameter int                 DATA_W    = 32,
    parameter bit                 SKID      = 1'b1,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    generate
        if (SKID == 1'b0) begin : g_single
            logic              valid_q;
            logic [DATA_W-1:0] main_q;
            logic              in_fire;
            logic              out_fire;

            assign in_ready  = !valid_q || out_ready;
            assign in_fire   = in_valid && in_ready;
            assign out_fire  = valid_q && out_ready;
            assign out_valid = valid_q;
            assign out_data  = main_q;
            assign count     = {1'b0, valid_q};

            // On a drain with no refill, main_q keeps its last value; only the valid bit drops.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    valid_q <= 1'b0;
                    main_q  <= RESET_VAL;
                end else if (in_fire) begin
                    valid_q <= 1'b1;
                    main_q  <= in_data;
                end else if (out_fire) begin
                    valid_q <= 1'b0;
                end
            end
        end else begin : g_skid
            state_t            state;
            logic              valid_q;
            logic              ready_q;
            logic [DATA_W-1:0] main_q;
            logic [DATA_W-1:0] skid_q;
            logic              in_fire;
            logic              out_fire;

            assign in_ready  = ready_q;
            assign in_fire   = in_valid && ready_q;
            assign out_fire  = valid_q && out_ready;
            assign out_valid = valid_q;
            assign out_data  = main_q;
            assign count     = state;

            // main_q always holds the oldest entry; skid_q only catches the word accepted
            // in the cycle the downstream stalled, and is drained back into main_q.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    main_q  <= RESET_VAL;
                    skid_q  <= RESET_VAL;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (in_fire) begin
                                state   <= BUSY;
                                valid_q <= 1'b1;
                                main_q  <= in_data;
                            end
                        end
                        BUSY: begin
                            if (in_fire && !out_fire) begin
                                state   <= FULL;
                                ready_q <= 1'b0;
                                skid_q  <= in_data;
                            end else if (!in_fire && out_fire) begin
                                state   <= EMPTY;
                                valid_q <= 1'b0;
                            end else if (in_fire && out_fire) begin
                                main_q  <= in_data;
                            end
                        end
                        FULL: begin
                            if (out_fire) begin
                                state   <= BUSY;
                                ready_q <= 1'b1;
                                main_q  <= skid_q;
                                skid_q  <= RESET_VAL;
                            end
                        end
                        default: begin
                            state   <= EMPTY;
                            valid_q <= 1'b0;
                            ready_q <= 1'b1;
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule
